// File: rtl/dmvm_coef_gen.sv
// Attention-coefficient generator: per-beat a1/a2 dot products through a registered
// adder tree, LeakyReLU + shift + saturate, packed per subgraph into a 2-deep output FIFO.
module dmvm_coef_gen #(
  parameter int NUM_FEATURE_OUT = 16,
  parameter int WH_DATA_WIDTH   = 12,
  parameter int DATA_WIDTH      = 8,
  parameter int MAX_NODES       = 6,
  parameter int NUM_NODE_WIDTH  = 3,
  parameter int COEF_SHIFT      = 2
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic                                            a_wr_en,
  input  logic [$clog2(NUM_FEATURE_OUT):0]                a_wr_addr,
  input  logic [DATA_WIDTH-1:0]                           a_wr_data,
  input  logic                                            wh_valid,
  output logic                                            wh_ready,
  input  logic [NUM_FEATURE_OUT*WH_DATA_WIDTH+NUM_NODE_WIDTH:0] wh_data,
  output logic                                            coef_valid,
  input  logic                                            coef_ready,
  output logic [MAX_NODES*DATA_WIDTH+NUM_NODE_WIDTH-1:0]  coef_data,
  output logic                                            busy,
  output logic                                            proto_err
);
  localparam int NF     = NUM_FEATURE_OUT;
  localparam int LOG_NF = $clog2(NF);
  localparam int NNW    = NUM_NODE_WIDTH;
  localparam int DW     = DATA_WIDTH;
  localparam int WHW    = WH_DATA_WIDTH;
  localparam int PW     = WHW + DW;
  localparam int SW     = PW + LOG_NF;
  localparam int EW     = SW + 1;
  localparam int CW     = MAX_NODES * DW + NNW;
  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_COLLECT = 1'b1;
  localparam logic [NNW-1:0] ONE_N  = NNW'(1);
  localparam logic signed [EW-1:0] SAT_MAX = (EW'(1) <<< (DW - 1)) - EW'(1);
  localparam logic signed [EW-1:0] SAT_MIN = -(EW'(1) <<< (DW - 1));

  typedef struct packed {
    logic           vld;
    logic           src;
    logic           last;
    logic [NNW-1:0] idx;
    logic [NNW-1:0] num;
  } tag_t;

  logic signed [DW-1:0]  a1_q [NF];
  logic signed [DW-1:0]  a2_q [NF];
  logic signed [WHW-1:0] wh_elem [NF];
  logic signed [SW-1:0]  t1_q [LOG_NF+1][NF];
  logic signed [SW-1:0]  t2_q [LOG_NF+1][NF];
  tag_t                  tag_q [LOG_NF+1];
  tag_t                  tag_in;

  logic [0:0]     state_q, state_d;
  logic [NNW-1:0] remaining_q, remaining_d, idx_q, idx_d, num_q, num_d;
  logic [1:0]     reserved_q, reserved_d, cnt_q;
  logic           err_d, proto_err_q, start, abort, accept, pop, push;
  logic           beat_src, bad_num, pipe_busy;
  logic [NNW-1:0] beat_num;

  logic signed [SW-1:0] s_src_q, s_eff;
  logic signed [EW-1:0] e_sum, e_lr, e_sh;
  logic [DW-1:0]        coef_val;
  logic [CW-1:0]        asm_q, asm_d, mem_q [2];
  logic                 done_q, wr_ptr_q, rd_ptr_q;
  tag_t                 tag_out;

  function automatic logic signed [SW-1:0] mul(input logic signed [DW-1:0] a,
                                               input logic signed [WHW-1:0] w);
    logic signed [PW-1:0] p;
    p = PW'(a) * PW'(w);
    return SW'(p);
  endfunction

  for (genvar gi = 0; gi < NF; gi++) begin : g_wh
    assign wh_elem[gi] = wh_data[NNW+1+gi*WHW +: WHW];
  end

  assign beat_src = wh_data[0];
  assign beat_num = wh_data[NNW:1];
  assign bad_num  = (beat_num == '0) || (int'(beat_num) > MAX_NODES);
  assign wh_ready = (state_q == ST_COLLECT) || (reserved_q < 2'd2);
  assign accept   = wh_valid && wh_ready;
  assign pop      = coef_valid && coef_ready;
  assign push     = done_q;

  // Beat acceptance, subgraph tracking and protocol-error detection.
  always_comb begin
    state_d = state_q; remaining_d = remaining_q; idx_d = idx_q; num_d = num_q;
    err_d = 1'b0; start = 1'b0; abort = 1'b0; tag_in = '0;
    if (accept) begin
      if (beat_src) begin
        if (bad_num) begin
          err_d = 1'b1;
        end else begin
          start       = 1'b1;
          abort       = (state_q == ST_COLLECT);
          err_d       = abort;
          remaining_d = beat_num - ONE_N;
          idx_d       = ONE_N;
          num_d       = beat_num;
          state_d     = (beat_num == ONE_N) ? ST_IDLE : ST_COLLECT;
          tag_in.vld  = 1'b1;
          tag_in.src  = 1'b1;
          tag_in.last = (beat_num == ONE_N);
          tag_in.num  = beat_num;
        end
      end else if (state_q == ST_IDLE) begin
        err_d = 1'b1;
      end else begin
        tag_in.vld  = 1'b1;
        tag_in.last = (remaining_q == ONE_N);
        tag_in.idx  = idx_q;
        tag_in.num  = num_q;
        remaining_d = remaining_q - ONE_N;
        idx_d       = idx_q + ONE_N;
        if (remaining_q == ONE_N) state_d = ST_IDLE;
      end
    end
  end

  // An aborting source beat releases the old reservation and takes a new one: net zero.
  assign reserved_d = reserved_q + 2'(start && !abort) - 2'(pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE; remaining_q <= '0; idx_q <= '0; num_q <= '0;
      reserved_q <= '0; proto_err_q <= 1'b0;
      for (int i = 0; i < NF; i++) begin
        a1_q[i] <= '0;
        a2_q[i] <= '0;
      end
    end else begin
      state_q <= state_d; remaining_q <= remaining_d; idx_q <= idx_d; num_q <= num_d;
      reserved_q <= reserved_d; proto_err_q <= err_d;
      if (a_wr_en) begin
        if (a_wr_addr[LOG_NF]) a2_q[a_wr_addr[LOG_NF-1:0]] <= a_wr_data;
        else                   a1_q[a_wr_addr[LOG_NF-1:0]] <= a_wr_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int l = 0; l <= LOG_NF; l++) begin
        tag_q[l] <= '0;
        for (int i = 0; i < NF; i++) begin
          t1_q[l][i] <= '0;
          t2_q[l][i] <= '0;
        end
      end
    end else begin
      tag_q[0] <= tag_in;
      for (int i = 0; i < NF; i++) begin
        t1_q[0][i] <= mul(a1_q[i], wh_elem[i]);
        t2_q[0][i] <= mul(a2_q[i], wh_elem[i]);
      end
      for (int l = 1; l <= LOG_NF; l++) begin
        tag_q[l] <= tag_q[l-1];
        for (int i = 0; i < NF; i++) begin
          if (i < (NF >> l)) begin
            t1_q[l][i] <= t1_q[l-1][2*i] + t1_q[l-1][2*i+1];
            t2_q[l][i] <= t2_q[l-1][2*i] + t2_q[l-1][2*i+1];
          end
        end
      end
    end
  end

  // Source beats pair with their own d1, which is only latched into s_src_q afterwards.
  always_comb begin
    tag_out = tag_q[LOG_NF];
    s_eff   = tag_out.src ? t1_q[LOG_NF][0] : s_src_q;
    e_sum   = EW'(s_eff) + EW'(t2_q[LOG_NF][0]);
    e_lr    = e_sum[EW-1] ? (e_sum >>> 3) : e_sum;
    e_sh    = e_lr >>> COEF_SHIFT;
    if (e_sh > SAT_MAX)      coef_val = SAT_MAX[DW-1:0];
    else if (e_sh < SAT_MIN) coef_val = SAT_MIN[DW-1:0];
    else                     coef_val = e_sh[DW-1:0];
    asm_d = asm_q;
    if (tag_out.vld) begin
      if (tag_out.src) begin
        asm_d          = '0;
        asm_d[NNW-1:0] = tag_out.num;
      end
      for (int j = 0; j < MAX_NODES; j++) begin
        if (tag_out.idx == NNW'(j)) asm_d[NNW+j*DW +: DW] = coef_val;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_src_q <= '0; asm_q <= '0; done_q <= 1'b0;
      mem_q[0] <= '0; mem_q[1] <= '0;
      wr_ptr_q <= 1'b0; rd_ptr_q <= 1'b0; cnt_q <= '0;
    end else begin
      if (tag_out.vld && tag_out.src) s_src_q <= t1_q[LOG_NF][0];
      asm_q  <= asm_d;
      done_q <= tag_out.vld && tag_out.last;
      if (push) begin
        mem_q[wr_ptr_q] <= asm_q;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_q + 2'(push) - 2'(pop);
    end
  end

  always_comb begin
    pipe_busy = done_q;
    for (int l = 0; l <= LOG_NF; l++) pipe_busy = pipe_busy | tag_q[l].vld;
  end

  assign coef_valid = (cnt_q != 2'd0);
  assign coef_data  = mem_q[rd_ptr_q];
  assign busy       = (reserved_q != 2'd0) || pipe_busy;
  assign proto_err  = proto_err_q;
endmodule

// File: tb/tb_dmvm_coef_gen.sv
// Bench for dmvm_coef_gen: table vectors, hand-written corner sequences and randomized
// traffic, all checked against an arithmetic subgraph model kept here.
module tb_dmvm_coef_gen;
  localparam int NF = 16, MN = 6, CW = MN * 8 + 3;

  logic          clk = 1'b0, rst = 1'b1, a_wr_en = 1'b0;
  logic [4:0]    a_wr_addr = '0;
  logic [7:0]    a_wr_data = '0;
  logic          wh_valid = 1'b0, wh_ready, coef_valid, coef_ready = 1'b1, busy, proto_err;
  logic [195:0]  wh_data = '0;
  logic [CW-1:0] coef_data;

  always #5 clk = ~clk;

  dmvm_coef_gen dut (
    .clk(clk), .rst(rst), .a_wr_en(a_wr_en), .a_wr_addr(a_wr_addr), .a_wr_data(a_wr_data),
    .wh_valid(wh_valid), .wh_ready(wh_ready), .wh_data(wh_data),
    .coef_valid(coef_valid), .coef_ready(coef_ready), .coef_data(coef_data),
    .busy(busy), .proto_err(proto_err)
  );

  int tests = 0, fails = 0;
  int a1m[NF], a2m[NF];
  bit collecting = 0, err_pending = 0, rand_ready = 0, last_ready;
  int need, got, s_src, cyc = 0, pop_cnt = 0, acc_cnt = 0, err_cnt = 0;
  int coefs[MN];
  int last_pop_cyc, last_acc_cyc;
  logic [CW-1:0] exp_q[$];
  logic [CW-1:0] last_word;

  typedef struct { int a_val; int wh_val; int n; int coef; } vec_t;
  vec_t tbl[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int f_coef(input int e);
    int v;
    v = e;
    if (v < 0) v = v >>> 3;
    v = v >>> 2;
    if (v > 127) v = 127;
    if (v < -128) v = -128;
    return v;
  endfunction

  function automatic logic [CW-1:0] pack_model(input int n);
    logic [CW-1:0] w;
    w = '0;
    w[2:0] = n[2:0];
    for (int j = 0; j < n; j++) w[3+8*j +: 8] = coefs[j][7:0];
    return w;
  endfunction

  function automatic logic [CW-1:0] mk_uniform(input int c, input int n);
    logic [CW-1:0] w;
    w = '0;
    w[2:0] = n[2:0];
    for (int j = 0; j < n; j++) w[3+8*j +: 8] = c[7:0];
    return w;
  endfunction

  task automatic model_beat(input logic [195:0] d);
    int n, dot1, dot2;
    logic signed [11:0] v;
    n = int'(d[3:1]);
    dot1 = 0; dot2 = 0;
    for (int i = 0; i < NF; i++) begin
      v = d[4+12*i +: 12];
      dot1 += a1m[i] * int'(v);
      dot2 += a2m[i] * int'(v);
    end
    if (d[0]) begin
      if (n == 0 || n > MN) begin
        err_pending = 1;
      end else begin
        if (collecting) err_pending = 1;
        for (int j = 0; j < MN; j++) coefs[j] = 0;
        s_src = dot1; need = n; got = 1;
        coefs[0] = f_coef(dot1 + dot2);
        collecting = (n > 1);
        if (n == 1) exp_q.push_back(pack_model(n));
      end
    end else if (!collecting) begin
      err_pending = 1;
    end else begin
      coefs[got] = f_coef(s_src + dot2);
      got++;
      if (got == need) begin
        collecting = 0;
        exp_q.push_back(pack_model(need));
      end
    end
  endtask

  task automatic step();
    bit acc, pop, ready_m, err_exp;
    @(negedge clk);
    ready_m = collecting || (exp_q.size() < 2);
    last_ready = wh_ready;
    check("wh_ready", wh_ready, ready_m);
    check("proto_err", proto_err, err_pending);
    if (proto_err) err_cnt++;
    acc = wh_valid && wh_ready;
    pop = coef_valid && coef_ready;
    err_pending = 0;
    if (pop) begin
      pop_cnt++; last_word = coef_data; last_pop_cyc = cyc;
      check("word_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) check("coef_data", coef_data, exp_q.pop_front());
    end
    if (acc) begin
      acc_cnt++; last_acc_cyc = cyc;
      model_beat(wh_data);
    end
    if (a_wr_en) begin
      if (a_wr_addr[4]) a2m[a_wr_addr[3:0]] = int'($signed(a_wr_data));
      else              a1m[a_wr_addr[3:0]] = int'($signed(a_wr_data));
    end
    err_exp = err_pending;
    err_pending = err_exp;
    cyc++;
    @(posedge clk); #1;
    if (rand_ready) coef_ready = ($urandom_range(3) != 0);
  endtask

  task automatic set_beat(input bit src, input int n, input int whv[NF]);
    wh_data = '0;
    wh_data[0] = src;
    wh_data[3:1] = n[2:0];
    for (int i = 0; i < NF; i++) wh_data[4+12*i +: 12] = whv[i][11:0];
    wh_valid = 1'b1;
  endtask

  task automatic send_beat(input bit src, input int n, input int whv[NF]);
    int a0;
    bit ok;
    set_beat(src, n, whv);
    a0 = acc_cnt; ok = 0;
    for (int k = 0; k < 100 && !ok; k++) begin
      step();
      ok = (acc_cnt != a0);
    end
    check("send_accept", ok, 1);
    wh_valid = 1'b0;
  endtask

  task automatic write_a(input int addr, input int val);
    a_wr_en = 1'b1; a_wr_addr = addr[4:0]; a_wr_data = val[7:0];
    step();
    a_wr_en = 1'b0;
  endtask

  task automatic drain();
    rand_ready = 0; coef_ready = 1'b1; wh_valid = 1'b0;
    for (int k = 0; k < 300 && exp_q.size() != 0; k++) step();
    repeat (10) step();
    check("drain_queue", exp_q.size(), 0);
    check("drain_busy", busy, 0);
    check("drain_valid", coef_valid, 0);
  endtask

  task automatic check_reset_outputs();
    check("rst_wh_ready", wh_ready, 1);
    check("rst_coef_valid", coef_valid, 0);
    check("rst_coef_data", coef_data, 0);
    check("rst_busy", busy, 0);
    check("rst_proto_err", proto_err, 0);
  endtask

  task automatic fill(output int whv[NF], input int v);
    for (int i = 0; i < NF; i++) whv[i] = v;
  endtask

  initial begin
    int whv[NF];
    int p0, a0, e0, n, k;
    logic [CW-1:0] w;
    for (int i = 0; i < NF; i++) begin a1m[i] = 0; a2m[i] = 0; end

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1;
    rst = 1'b0;
    step();

    tbl[0] = '{1, 1, 3, 8};     tbl[1] = '{1, -1, 3, -1};  tbl[2] = '{10, 100, 2, 127};
    tbl[3] = '{10, -100, 1, -128}; tbl[4] = '{2, 3, 6, 48}; tbl[5] = '{-3, 5, 4, -15};
    tbl[6] = '{0, 77, 5, 0};
    for (int t = 0; t < 7; t++) begin
      for (int ad = 0; ad < 32; ad++) write_a(ad, tbl[t].a_val);
      fill(whv, tbl[t].wh_val);
      for (int b = 0; b < tbl[t].n; b++) send_beat(b == 0, tbl[t].n, whv);
      p0 = pop_cnt;
      for (int c = 0; c < 30 && pop_cnt == p0; c++) step();
      check("tbl_word", last_word, mk_uniform(tbl[t].coef, tbl[t].n));
      check("tbl_latency", last_pop_cyc - last_acc_cyc, 7);
      $display("[TB] vector %0d: a=%0d wh=%0d n=%0d word=0x%0h", t, tbl[t].a_val,
               tbl[t].wh_val, tbl[t].n, last_word);
    end

    // Backpressure: two 1-node subgraphs fill the reservation, the rest must wait.
    for (int ad = 0; ad < 32; ad++) write_a(ad, 1);
    coef_ready = 1'b0;
    a0 = acc_cnt; p0 = pop_cnt;
    fill(whv, 1); send_beat(1, 1, whv);
    fill(whv, 2); send_beat(1, 1, whv);
    fill(whv, 3); set_beat(1, 1, whv);
    step();
    check("bp_ready_low", last_ready, 0);
    repeat (8) step();
    check("bp_accepted", acc_cnt - a0, 2);
    check("bp_valid_held", coef_valid, 1);
    check("bp_head_word", coef_data, mk_uniform(8, 1));
    coef_ready = 1'b1;
    send_beat(1, 1, whv);
    fill(whv, 4); send_beat(1, 1, whv);
    drain();
    check("bp_words", pop_cnt - p0, 4);
    check("bp_last_word", last_word, mk_uniform(32, 1));

    // Non-source beat while idle.
    e0 = err_cnt; p0 = pop_cnt;
    fill(whv, 9); send_beat(0, 2, whv);
    drain();
    check("perr_idle_pulse", err_cnt - e0, 1);
    check("perr_idle_words", pop_cnt - p0, 0);

    // Source beat arriving mid-subgraph aborts the old one.
    e0 = err_cnt; p0 = pop_cnt;
    fill(whv, 5); send_beat(1, 4, whv); send_beat(0, 4, whv);
    fill(whv, 2); send_beat(1, 2, whv);
    fill(whv, 3); send_beat(0, 2, whv);
    drain();
    w = '0; w[2:0] = 3'd2; w[10:3] = 8'd16; w[18:11] = 8'd20;
    check("abort_pulse", err_cnt - e0, 1);
    check("abort_words", pop_cnt - p0, 1);
    check("abort_word", last_word, w);

    // Illegal node counts.
    e0 = err_cnt; p0 = pop_cnt;
    fill(whv, 1); send_beat(1, 7, whv); send_beat(1, 0, whv);
    drain();
    check("badn_pulses", err_cnt - e0, 2);
    check("badn_words", pop_cnt - p0, 0);

    // Reset with a word in the FIFO and a subgraph being collected.
    coef_ready = 1'b0;
    fill(whv, 1); send_beat(1, 1, whv);
    for (int c = 0; c < 30 && !coef_valid; c++) step();
    check("mid_word_ready", coef_valid, 1);
    send_beat(1, 3, whv); send_beat(0, 3, whv);
    rst = 1'b1; wh_valid = 1'b0; a_wr_en = 1'b0; coef_ready = 1'b1;
    collecting = 0; err_pending = 0; exp_q.delete();
    for (int i = 0; i < NF; i++) begin a1m[i] = 0; a2m[i] = 0; end
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1;
    rst = 1'b0;
    p0 = pop_cnt;
    write_a(0, 3); write_a(16, 1); write_a(21, -2);
    for (int i = 0; i < NF; i++) whv[i] = int'($urandom_range(400)) - 200;
    send_beat(1, 2, whv);
    for (int i = 0; i < NF; i++) whv[i] = int'($urandom_range(400)) - 200;
    send_beat(0, 2, whv);
    drain();
    check("post_reset_words", pop_cnt - p0, 1);

    // Randomized traffic with random backpressure and occasional protocol errors.
    for (int r = 0; r < 3; r++) begin
      for (int ad = 0; ad < 32; ad++) write_a(ad, int'($urandom_range(40)) - 20);
      rand_ready = 1;
      p0 = pop_cnt;
      for (int s = 0; s < 12; s++) begin
        for (int i = 0; i < NF; i++) whv[i] = int'($urandom_range(600)) - 300;
        if ($urandom_range(9) == 0) send_beat(1, ($urandom_range(1) != 0) ? 0 : 7, whv);
        n = int'($urandom_range(6, 1));
        k = n;
        if (s != 11 && n > 1 && $urandom_range(7) == 0) k = int'($urandom_range(n - 1, 1));
        for (int b = 0; b < k; b++) begin
          for (int i = 0; i < NF; i++) whv[i] = int'($urandom_range(600)) - 300;
          send_beat(b == 0, n, whv);
        end
      end
      drain();
      $display("[TB] random round %0d: %0d words popped", r, pop_cnt - p0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
